// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM responder slice.
package sram_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   // One initiator-side access request as seen on the SRAM port.
   typedef struct packed {
      logic              en;
      logic [BE_W-1:0]   wen;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
   } sram_req_t;

   // Replace only the byte lanes selected by wen; other lanes keep old data.
   function automatic logic [WORD_W-1:0] merge_bytes(
      input logic [WORD_W-1:0] old,
      input logic [WORD_W-1:0] wdata,
      input logic [BE_W-1:0]   wen
   );
      logic [WORD_W-1:0] res;
      res = old;
      for (int i = 0; i < BE_W; i++) begin
         if (wen[i]) begin
            res[8*i +: 8] = wdata[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_byte_lane.sv
// One 8-bit byte lane of the responder memory: single port, read-first,
// registered read. Kept free of reset so it maps onto block RAM.
module sram_byte_lane #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];
   logic [7:0] rdata_reg;

   // Read-first port: capture the old byte, then optionally overwrite it.
   // The read register only moves on an enabled access, so it holds while idle.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata_reg <= mem[addr];
         if (we) begin
            mem[addr] <= wdata;
         end
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/sram_responder.sv
// Synchronous SRAM responder: address decode with range check, byte-lane
// writes, one-cycle read latency, error pulse and saturating access counters.
module sram_responder
   import sram_pkg::*;
#(
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter bit          READ_ONLY = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_en,
   input  logic [3:0]  sram_wen,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        sram_err,
   output logic [31:0] rd_cnt,
   output logic [31:0] wr_cnt
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   sram_req_t         req;
   logic [32:0]       off;
   logic [29:0]       idx;
   logic              in_range;
   logic              accept;
   logic              is_write;
   logic              lane_en;
   logic              do_rd;
   logic              do_wr;
   logic              do_err;
   logic [BE_W-1:0]   lane_we;
   logic [WORD_W-1:0] lane_rdata;
   logic              unused_off_lsb;

   logic              out_sel_reg;
   logic              err_reg;
   logic [31:0]       rd_cnt_reg;
   logic [31:0]       wr_cnt_reg;

   assign req = '{en: sram_en, wen: sram_wen, addr: sram_addr, wdata: sram_wdata};

   // Decode: a 33-bit subtraction whose borrow flags below-base addresses.
   // Reset gates the lane enables so an access caught by reset is dropped.
   always_comb begin
      off      = {1'b0, req.addr} - {1'b0, BASE_ADDR};
      idx      = off[31:2];
      in_range = !off[32] && ({2'b00, idx} < DEPTH_W);
      accept   = req.en && !reset;
      is_write = (req.wen != '0);
      lane_en  = accept && in_range;
      do_rd    = lane_en && !is_write;
      do_wr    = lane_en && is_write && !READ_ONLY;
      do_err   = accept && !in_range;
      lane_we  = do_wr ? req.wen : '0;
   end

   assign unused_off_lsb = &{1'b0, off[1:0]};

   for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      sram_byte_lane #(
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_lane (
         .clk   (clk),
         .en    (lane_en),
         .we    (lane_we[gi]),
         .addr  (idx[AW-1:0]),
         .wdata (req.wdata[8*gi +: 8]),
         .rdata (lane_rdata[8*gi +: 8])
      );
   end

   // Output select, error pulse and saturating counters. The memory read
   // register cannot be reset, so a resettable select forces rdata to zero
   // after reset or an out-of-range access until the next in-range access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_sel_reg <= 1'b0;
         err_reg     <= 1'b0;
         rd_cnt_reg  <= '0;
         wr_cnt_reg  <= '0;
      end else begin
         err_reg <= do_err;
         if (lane_en) begin
            out_sel_reg <= 1'b1;
         end else if (do_err) begin
            out_sel_reg <= 1'b0;
         end
         if (do_rd && (rd_cnt_reg != 32'hFFFF_FFFF)) begin
            rd_cnt_reg <= rd_cnt_reg + 32'd1;
         end
         if (do_wr && (wr_cnt_reg != 32'hFFFF_FFFF)) begin
            wr_cnt_reg <= wr_cnt_reg + 32'd1;
         end
      end
   end

   assign sram_rdata = out_sel_reg ? lane_rdata : '0;
   assign sram_err   = err_reg;
   assign rd_cnt     = rd_cnt_reg;
   assign wr_cnt     = wr_cnt_reg;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three configurations share one stimulus stream
// (RAM at base 0, small RAM at base 0x100, small ROM at base 0); each is
// compared every cycle against its own behavioural memory model.
module tb_sram_responder;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata_o [3];
   logic        err_o   [3];
   logic [31:0] rdc_o   [3];
   logic [31:0] wrc_o   [3];

   // Reference model state
   logic [31:0] mm     [3][256];
   logic [31:0] base_m [3];
   int          depth_m[3];
   bit          ro_m   [3];
   logic [31:0] er  [3];
   logic        ee  [3];
   logic [31:0] erc [3];
   logic [31:0] ewc [3];

   int errors;
   int checks;
   int txn;

   sram_responder #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .READ_ONLY(1'b0)) dut0 (
      .clk(clk), .reset(reset), .sram_en(en), .sram_wen(wen), .sram_addr(addr),
      .sram_wdata(wdata), .sram_rdata(rdata_o[0]), .sram_err(err_o[0]),
      .rd_cnt(rdc_o[0]), .wr_cnt(wrc_o[0]));

   sram_responder #(.DEPTH(16), .BASE_ADDR(32'h0000_0100), .READ_ONLY(1'b0)) dut1 (
      .clk(clk), .reset(reset), .sram_en(en), .sram_wen(wen), .sram_addr(addr),
      .sram_wdata(wdata), .sram_rdata(rdata_o[1]), .sram_err(err_o[1]),
      .rd_cnt(rdc_o[1]), .wr_cnt(wrc_o[1]));

   sram_responder #(.DEPTH(16), .BASE_ADDR(32'h0000_0000), .READ_ONLY(1'b1)) dut2 (
      .clk(clk), .reset(reset), .sram_en(en), .sram_wen(wen), .sram_addr(addr),
      .sram_wdata(wdata), .sram_rdata(rdata_o[2]), .sram_err(err_o[2]),
      .rd_cnt(rdc_o[2]), .wr_cnt(wrc_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         check("rdata", k, rdata_o[k], er[k]);
         check("err", k, {31'b0, err_o[k]}, {31'b0, ee[k]});
         check("rd_cnt", k, rdc_o[k], erc[k]);
         check("wr_cnt", k, wrc_o[k], ewc[k]);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Behavioural response of configuration k to the access on the bus now.
   task automatic model_step(input int k);
      longint unsigned a;
      longint unsigned b;
      longint unsigned w;
      if (!en) begin
         ee[k] = 1'b0;
         return;
      end
      a = longint'(addr);
      b = longint'(base_m[k]);
      if (a < b || ((a - b) / 4) >= longint'(depth_m[k])) begin
         er[k] = 32'h0;
         ee[k] = 1'b1;
         return;
      end
      w     = (a - b) / 4;
      ee[k] = 1'b0;
      er[k] = mm[k][w];
      if (wen == 4'h0) begin
         erc[k] = sat_inc(erc[k]);
      end else if (!ro_m[k]) begin
         for (int i = 0; i < 4; i++) begin
            if (wen[i]) mm[k][w][8*i +: 8] = wdata[8*i +: 8];
         end
         ewc[k] = sat_inc(ewc[k]);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         er[k] = '0; ee[k] = 1'b0; erc[k] = '0; ewc[k] = '0;
      end
   endtask

   // One access: drive at the falling edge, let the rising edge take it,
   // compare at the next falling edge.
   task automatic do_cycle(input logic e, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      en = e; wen = we; addr = a; wdata = d;
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      @(negedge clk);
      txn++;
      $display("txn %0d en=%0b wen=%h addr=%h wdata=%h rdata=%h/%h/%h err=%0b%0b%0b",
               txn, e, we, a, d, rdata_o[0], rdata_o[1], rdata_o[2], err_o[0], err_o[1], err_o[2]);
      check_all();
   endtask

   task automatic preload(input int k, input int i, input logic [31:0] v);
      mm[k][i] = v;
      case (k)
         0: begin
            dut0.g_lane[0].u_lane.mem[i] = v[7:0];   dut0.g_lane[1].u_lane.mem[i] = v[15:8];
            dut0.g_lane[2].u_lane.mem[i] = v[23:16]; dut0.g_lane[3].u_lane.mem[i] = v[31:24];
         end
         1: begin
            dut1.g_lane[0].u_lane.mem[i] = v[7:0];   dut1.g_lane[1].u_lane.mem[i] = v[15:8];
            dut1.g_lane[2].u_lane.mem[i] = v[23:16]; dut1.g_lane[3].u_lane.mem[i] = v[31:24];
         end
         default: begin
            dut2.g_lane[0].u_lane.mem[i] = v[7:0];   dut2.g_lane[1].u_lane.mem[i] = v[15:8];
            dut2.g_lane[2].u_lane.mem[i] = v[23:16]; dut2.g_lane[3].u_lane.mem[i] = v[31:24];
         end
      endcase
   endtask

   initial begin
      logic [31:0] bnd [10];
      logic [31:0] a;
      logic [31:0] prev_a;
      logic [3:0]  w;
      int          r;

      errors = 0; checks = 0; txn = 0;
      base_m  = '{32'h0, 32'h100, 32'h0};
      depth_m = '{256, 16, 16};
      ro_m    = '{1'b0, 1'b0, 1'b1};
      bnd     = '{32'h0, 32'h3C, 32'h40, 32'hFC, 32'h100, 32'h13C, 32'h140, 32'h3FC, 32'h400, 32'hFFFF_FFFC};

      reset = 1'b1; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
      model_reset();
      for (int i = 0; i < 256; i++) preload(0, i, $urandom);
      for (int i = 0; i < 16; i++) preload(1, i, $urandom);
      for (int i = 0; i < 16; i++) preload(2, i, $urandom);
      preload(1, 0, 32'hCAFE_0001);
      preload(2, 0, 32'h2408_0001);

      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // Full write then read of 0x10; mem[3] seeded for the reset test
      do_cycle(1'b1, 4'hF, 32'h0000_000C, 32'hDEAD_BEEF);
      do_cycle(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
      do_cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("wr_then_rd", 0, rdata_o[0], 32'h1234_5678);

      // Partial write: read-first data, then merged word
      do_cycle(1'b1, 4'b0110, 32'h0000_0010, 32'hAABB_CCDD);
      check("partial_readfirst", 0, rdata_o[0], 32'h1234_5678);
      do_cycle(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      check("partial_merge", 0, rdata_o[0], 32'h12BB_CC78);

      // Out of range on the based configuration: above top, below base, write above top
      do_cycle(1'b1, 4'h0, 32'h0000_0140, 32'h0);
      check("oor_hi_err", 1, {31'b0, err_o[1]}, 32'h1);
      check("oor_hi_rdata", 1, rdata_o[1], 32'h0);
      do_cycle(1'b1, 4'h0, 32'h0000_00FC, 32'h0);
      check("oor_lo_err", 1, {31'b0, err_o[1]}, 32'h1);
      do_cycle(1'b1, 4'hF, 32'h0000_0140, 32'h5555_AAAA);
      check("oor_wr_cnt", 1, wrc_o[1], 32'h0);

      // Idle hold after an in-range read
      do_cycle(1'b1, 4'h0, 32'h0000_0100, 32'h0);
      check("base_read", 1, rdata_o[1], 32'hCAFE_0001);
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b0, 4'($urandom), $urandom, $urandom);
         check("idle_hold", 1, rdata_o[1], 32'hCAFE_0001);
         check("idle_err", 1, {31'b0, err_o[1]}, 32'h0);
      end

      // Read-only configuration ignores writes
      do_cycle(1'b1, 4'hF, 32'h0000_0000, 32'h0BAD_F00D);
      check("ro_write_rdata", 2, rdata_o[2], 32'h2408_0001);
      check("ro_wr_cnt", 2, wrc_o[2], 32'h0);
      do_cycle(1'b1, 4'h0, 32'h0000_0000, 32'h0);
      check("ro_read_back", 2, rdata_o[2], 32'h2408_0001);

      // Mid-run reset between edges, with a write held across an edge
      @(negedge clk);
      en = 1'b1; wen = 4'hF; addr = 32'h0000_000C; wdata = 32'hFFFF_FFFF;
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b0;
      do_cycle(1'b1, 4'h0, 32'h0000_000C, 32'h0);
      check("after_reset_mem", 0, rdata_o[0], 32'hDEAD_BEEF);
      check("after_reset_rdcnt", 0, rdc_o[0], 32'h1);

      // Random traffic with boundary and repeated addresses
      prev_a = 32'h10;
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 3)      a = 32'($urandom_range(0, 32'h17F));
         else if (r <= 5) a = 32'h100 + 32'($urandom_range(0, 32'h4F));
         else if (r <= 7) a = prev_a;
         else if (r == 8) a = bnd[$urandom_range(0, 9)];
         else             a = $urandom;
         w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         prev_a = a;
         do_cycle($urandom_range(0, 4) != 0, w, a, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
